// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 execute-stage hazard controller: forwarding selects,
// the zero register index and the per-stage register-metadata record.
package hazard_pkg;

  localparam int unsigned RegW = 5;
  localparam logic [RegW-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rn;
    logic [RegW-1:0] rm;
    logic            uses_rm;
    logic [RegW-1:0] rd;
    logic            regWrite;
    logic            memRead;
    logic            branch;
    logic            uncond;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // True when the record will write a real register that matches src.
  function automatic logic writes_reg(stage_rec_t rec, logic [RegW-1:0] src);
    return rec.valid & rec.regWrite & (rec.rd != XZR) & (rec.rd == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one ALU operand: picks the youngest in-flight producer of i_src.
module fwd_select
  import hazard_pkg::*;
(
  input  stage_rec_t      i_mem,
  input  stage_rec_t      i_wb,
  input  logic [RegW-1:0] i_src,
  output fwd_sel_t        o_sel
);

  logic w_unused;
  assign w_unused = ^{i_mem.rn, i_mem.rm, i_mem.uses_rm, i_mem.memRead, i_mem.branch,
                      i_mem.uncond, i_wb.rn, i_wb.rm, i_wb.uses_rm, i_wb.memRead,
                      i_wb.branch, i_wb.uncond};

  always_comb begin
    o_sel = FWD_REG;
    if (writes_reg(i_mem, i_src)) begin
      o_sel = FWD_MEM;
    end else if (writes_reg(i_wb, i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: shadows EX/MEM/WB destination metadata and drives
// forwarding selects, load-use stall, branch flush and stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic          id_uses_rm,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regWrite,
  input  logic          id_memRead,
  input  logic          id_branch,
  input  logic          id_uncond,
  input  logic          zero_E,
  output logic [1:0]    forwardA,
  output logic [1:0]    forwardB,
  output logic          stall,
  output logic          flush_if,
  output logic          flush_id,
  output logic          pcsrc,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  stage_rec_t    r_ex, r_mem, r_wb;
  logic [CW-1:0] r_stall_cnt, r_flush_cnt;

  stage_rec_t w_id_rec;
  fwd_sel_t   w_fwd_a, w_fwd_b;
  logic       w_load_use, w_taken, w_stall;
  logic       w_unused;

  assign w_id_rec = '{
    valid:    id_valid,
    rn:       id_rn,
    rm:       id_rm,
    uses_rm:  id_uses_rm,
    rd:       id_rd,
    regWrite: id_regWrite,
    memRead:  id_memRead,
    branch:   id_branch,
    uncond:   id_uncond
  };

  assign w_unused = ^{r_ex.uses_rm, r_ex.regWrite};

  fwd_select u_fwd_a (
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .i_src (r_ex.rn),
    .o_sel (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .i_src (r_ex.rm),
    .o_sel (w_fwd_b)
  );

  assign w_load_use = r_ex.valid & r_ex.memRead & (r_ex.rd != XZR) & id_valid &
                      ((r_ex.rd == id_rn) | (id_uses_rm & (r_ex.rd == id_rm)));
  assign w_taken    = ~reset & r_ex.valid & (r_ex.uncond | (r_ex.branch & zero_E));
  // A taken branch squashes the ID instruction, so stalling it would be pointless.
  assign w_stall    = ~reset & w_load_use & ~w_taken;

  assign forwardA  = (~reset & r_ex.valid) ? w_fwd_a : FWD_REG;
  assign forwardB  = (~reset & r_ex.valid) ? w_fwd_b : FWD_REG;
  assign stall     = w_stall;
  assign flush_if  = w_taken;
  assign flush_id  = w_taken;
  assign pcsrc     = w_taken;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= BUBBLE;
      r_mem       <= BUBBLE;
      r_wb        <= BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (w_stall | w_taken) ? BUBBLE : w_id_rec;
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CW'(1);
      end
      if (w_taken) begin
        r_flush_cnt <= r_flush_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, counter wrap sequences and random
// stimulus, all compared against a pipeline model held in the bench.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rn = '0, id_rm = '0, id_rd = '0;
  logic          id_uses_rm = 1'b0, id_regWrite = 1'b0, id_memRead = 1'b0;
  logic          id_branch = 1'b0, id_uncond = 1'b0, zero_E = 1'b0;
  logic [1:0]    forwardA, forwardB;
  logic          stall, flush_if, flush_id, pcsrc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CW(CW), .RW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .id_rd       (id_rd),
    .id_regWrite (id_regWrite),
    .id_memRead  (id_memRead),
    .id_branch   (id_branch),
    .id_uncond   (id_uncond),
    .zero_E      (zero_E),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .stall       (stall),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .pcsrc       (pcsrc),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  typedef struct {
    bit       v;
    bit [4:0] rn, rm;
    bit       urm;
    bit [4:0] rd;
    bit       rw, mr, br, un;
  } ins_t;

  typedef struct {
    ins_t     id;
    bit       z;
    bit [1:0] fa, fb;
    bit       st, tk;
  } vec_t;

  ins_t        m_ex, m_mem, m_wb;
  int unsigned m_scnt, m_fcnt;
  bit          cnt_known;
  int          checks, errors;
  vec_t        tab[$];

  function automatic ins_t mk(bit v, int rn, int rm, bit urm, int rd, bit rw, bit mr, bit br,
                              bit un);
    ins_t r;
    r.v = v; r.rn = rn[4:0]; r.rm = rm[4:0]; r.urm = urm; r.rd = rd[4:0];
    r.rw = rw; r.mr = mr; r.br = br; r.un = un;
    return r;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic ins_t add(int rd, int rn, int rm);
    return mk(1, rn, rm, 1, rd, 1, 0, 0, 0);
  endfunction
  function automatic ins_t ldur(int rd, int rn);
    return mk(1, rn, 0, 0, rd, 1, 1, 0, 0);
  endfunction
  function automatic ins_t cbz(int rt);
    return mk(1, 0, rt, 1, 0, 0, 0, 1, 0);
  endfunction
  function automatic ins_t bra();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic vec_t vec(ins_t id, bit z, bit [1:0] fa, bit [1:0] fb, bit st, bit tk);
    vec_t t;
    t.id = id; t.z = z; t.fa = fa; t.fb = fb; t.st = st; t.tk = tk;
    return t;
  endfunction

  // Youngest producer wins; X31 is never a producer.
  function automatic bit produces(ins_t p, bit [4:0] src);
    return p.v && p.rw && (p.rd != 5'd31) && (p.rd == src);
  endfunction

  function automatic bit [1:0] model_fwd(bit [4:0] src);
    if (!m_ex.v) return 2'b00;
    if (produces(m_mem, src)) return 2'b10;
    if (produces(m_wb, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(vec_t t, bit rst, bit use_tab);
    bit [1:0] e_fa, e_fb;
    bit       e_tk, e_st, e_ld;
    @(negedge clk);
    reset = rst; zero_E = t.z;
    id_valid = t.id.v; id_rn = t.id.rn; id_rm = t.id.rm; id_uses_rm = t.id.urm;
    id_rd = t.id.rd; id_regWrite = t.id.rw; id_memRead = t.id.mr;
    id_branch = t.id.br; id_uncond = t.id.un;
    #1;
    e_tk = !rst && m_ex.v && (m_ex.un || (m_ex.br && t.z));
    e_ld = m_ex.v && m_ex.mr && (m_ex.rd != 5'd31) && t.id.v &&
           ((m_ex.rd == t.id.rn) || (t.id.urm && (m_ex.rd == t.id.rm)));
    e_st = !rst && e_ld && !e_tk;
    e_fa = rst ? 2'b00 : model_fwd(m_ex.rn);
    e_fb = rst ? 2'b00 : model_fwd(m_ex.rm);
    check("forwardA", 32'(forwardA), 32'(e_fa));
    check("forwardB", 32'(forwardB), 32'(e_fb));
    check("stall", 32'(stall), 32'(e_st));
    check("flush_if", 32'(flush_if), 32'(e_tk));
    check("flush_id", 32'(flush_id), 32'(e_tk));
    check("pcsrc", 32'(pcsrc), 32'(e_tk));
    if (cnt_known) begin
      check("stall_cnt", 32'(stall_cnt), m_scnt);
      check("flush_cnt", 32'(flush_cnt), m_fcnt);
    end
    if (use_tab) begin
      check("tab_forwardA", 32'(forwardA), 32'(t.fa));
      check("tab_forwardB", 32'(forwardB), 32'(t.fb));
      check("tab_stall", 32'(stall), 32'(t.st));
      check("tab_pcsrc", 32'(pcsrc), 32'(t.tk));
    end
    @(posedge clk);
    if (rst) begin
      m_ex = nop(); m_mem = nop(); m_wb = nop();
      m_scnt = 0; m_fcnt = 0; cnt_known = 1'b1;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (e_st || e_tk) ? nop() : t.id;
      if (e_st) m_scnt = (m_scnt + 1) % (1 << CW);
      if (e_tk) m_fcnt = (m_fcnt + 1) % (1 << CW);
    end
  endtask

  function automatic bit [4:0] pick_reg();
    int unsigned k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  function automatic vec_t rand_vec();
    ins_t r;
    r = mk($urandom_range(0, 3) != 0, pick_reg(), pick_reg(), 1'($urandom), pick_reg(),
           1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0);
    return vec(r, 1'($urandom), 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) step(rand_vec(), 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cnt_known = 1'b0;
    m_ex = nop(); m_mem = nop(); m_wb = nop(); m_scnt = 0; m_fcnt = 0;

    do_reset(3);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);

    // Forward from MEM, then from WB.
    tab.push_back(vec(add(1, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(4, 1, 5), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b10, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(1, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(7, 8, 9), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(4, 1, 5), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b01, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    // Double write: MEM beats WB; then the same with X31.
    tab.push_back(vec(add(1, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(1, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(4, 1, 1), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b10, 2'b10, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(31, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(31, 2, 3), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(4, 31, 31), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),        0, 2'b00, 2'b00, 0, 0));
    // Load-use: one stall cycle, bubble, then WB forwarding; then an independent consumer.
    tab.push_back(vec(ldur(9, 0),     0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(10, 9, 9),  0, 2'b00, 2'b00, 1, 0));
    tab.push_back(vec(add(10, 9, 9),  0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b01, 2'b01, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(ldur(9, 0),     0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(10, 2, 3),  0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    // CBZ taken, CBZ not taken, unconditional B.
    tab.push_back(vec(cbz(5),         1, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(1, 2, 3),   1, 2'b00, 2'b00, 0, 1));
    tab.push_back(vec(nop(),          1, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(cbz(5),         0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(bra(),          0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 1));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));
    // Taken branch overrides a simultaneous load-use stall.
    tab.push_back(vec(mk(1, 0, 0, 0, 9, 1, 1, 0, 1), 0, 2'b00, 2'b00, 0, 0));
    tab.push_back(vec(add(10, 9, 9),  0, 2'b00, 2'b00, 0, 1));
    tab.push_back(vec(nop(),          0, 2'b00, 2'b00, 0, 0));

    foreach (tab[i]) step(tab[i], 1'b0, 1'b1);
    #1;
    check("directed_stall_cnt", 32'(stall_cnt), 32'd1);
    check("directed_flush_cnt", 32'(flush_cnt), 32'd3);

    // Flush counter wraps after 2^CW taken branches.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step(vec(bra(), 0, 0, 0, 0, 0), 1'b0, 1'b0);
      step(vec(nop(), 0, 0, 0, 0, 0), 1'b0, 1'b0);
      #1;
      if (i == 14) check("flush_cnt_max", 32'(flush_cnt), 32'd15);
      if (i == 15) check("flush_cnt_wrap", 32'(flush_cnt), 32'd0);
    end

    // Stall counter wraps after 2^CW load-use stalls.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      step(vec(ldur(9, 0), 0, 0, 0, 0, 0), 1'b0, 1'b0);
      step(vec(add(10, 9, 9), 0, 0, 0, 0, 0), 1'b0, 1'b0);
      step(vec(add(10, 9, 9), 0, 0, 0, 0, 0), 1'b0, 1'b0);
      #1;
      if (i == 14) check("stall_cnt_max", 32'(stall_cnt), 32'd15);
      if (i == 15) check("stall_cnt_wrap", 32'(stall_cnt), 32'd0);
    end

    // Random traffic with occasional mid-flight resets.
    for (int i = 0; i < 800; i++) begin
      step(rand_vec(), $urandom_range(0, 49) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
